// File: rtl/mr_wb_pkg.sv
// Shared types and constants for the mr_wb memory-bus arbiter family.
// Also provides the default XLEN and XLEN_GRAN used to size the bus.
package mr_wb_pkg;

    localparam int XLEN         = 32;
    localparam int XLEN_GRAN    = 2;
    localparam int ARB_NMASTERS = 2;

    // Master indices on the arbiter request vectors.
    localparam logic M_FETCH = 1'b0;
    localparam logic M_LDST  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1
    } e_arb_state;

    // Grant state that corresponds to a master index.
    function automatic e_arb_state gnt_state(input logic idx);
        return idx ? ARB_GNT1 : ARB_GNT0;
    endfunction

endpackage

// File: rtl/mr_wb_arb_pick.sv
// Combinational 2-way request picker.
// A lone requester always wins. On a tie, the winner is master 1 under fixed
// priority, or the master not granted last time when rr_en is set.
module mr_wb_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       winner
);

    // Choose the winning master index from the request vector.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = rr_en ? ~last : 1'b1;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master to one-slave pipelined Wishbone B4 arbiter.
// m0 is instruction fetch and m1 is load/store. The grant is registered and
// held while the granted master keeps cyc high.
// Optional feature: define MR_WB_ARB_RR_EN for a round-robin tie-break.
// Without it, m1 wins every tie.
module mr_wb_arb
    import mr_wb_pkg::*;
#(
    parameter int AW   = XLEN - XLEN_GRAN,
    parameter int DW   = XLEN,
    parameter int OUTW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_cyc_i,
    input  logic [1:0]          m_stb_i,
    input  logic [1:0]          m_we_i,
    input  logic [2*AW-1:0]     m_addr_i,
    input  logic [2*DW/8-1:0]   m_sel_i,
    input  logic [2*DW-1:0]     m_dat_i,
    output logic [1:0]          m_ack_o,
    output logic [1:0]          m_err_o,
    output logic [1:0]          m_stall_o,
    output logic [DW-1:0]       m_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_stall_i,
    input  logic [DW-1:0]       s_dat_i
);

    e_arb_state      state, state_nxt;
    logic [OUTW-1:0] out_cnt;
    logic [1:0]      pick_req;
    logic            winner;
    logic            pick_last;
    logic            pick_rr;
    logic            released;
    logic            rearb;
    logic            grant_evt;
    logic            granted;
    logic            src;
    logic            resp_ok;
    logic            cnt_inc;
    logic            cnt_dec;

`ifdef MR_WB_ARB_RR_EN
    logic last_gnt;

    // Remember which master received the most recent grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= 1'b0;
        end else if (grant_evt) begin
            last_gnt <= winner;
        end
    end

    assign pick_last = last_gnt;
    assign pick_rr   = 1'b1;
`else
    assign pick_last = 1'b0;
    assign pick_rr   = 1'b0;
`endif

    mr_wb_arb_pick u_pick (
        .req    (pick_req),
        .last   (pick_last),
        .rr_en  (pick_rr),
        .winner (winner)
    );

    // Register the grant state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next grant: arbitrate from IDLE, or on release hand off to the other master.
    always_comb begin
        pick_req  = '0;
        released  = 1'b0;
        state_nxt = state;
        case (state)
            ARB_IDLE: pick_req = m_cyc_i;
            ARB_GNT0: begin
                released = ~m_cyc_i[M_FETCH];
                pick_req = {m_cyc_i[M_LDST], 1'b0};
            end
            ARB_GNT1: begin
                released = ~m_cyc_i[M_LDST];
                pick_req = {1'b0, m_cyc_i[M_FETCH]};
            end
            default: pick_req = '0;
        endcase
        rearb     = (state == ARB_IDLE) | released;
        grant_evt = rearb & (|pick_req);
        if (rearb) begin
            state_nxt = grant_evt ? gnt_state(winner) : ARB_IDLE;
        end
    end

    assign granted = (state == ARB_GNT0) || (state == ARB_GNT1);
    assign src     = (state != ARB_GNT0);
    assign resp_ok = (out_cnt != '0);
    assign m_dat_o = s_dat_i;

    // Mux the slave request from the granted master and steer responses back to it.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        s_we_o    = m_we_i[src];
        s_addr_o  = src ? m_addr_i[2*AW-1:AW]     : m_addr_i[AW-1:0];
        s_sel_o   = src ? m_sel_i[2*DW/8-1:DW/8]  : m_sel_i[DW/8-1:0];
        s_dat_o   = src ? m_dat_i[2*DW-1:DW]      : m_dat_i[DW-1:0];
        if (granted) begin
            s_cyc_o        = m_cyc_i[src];
            s_stb_o        = m_stb_i[src];
            m_stall_o[src] = s_stall_i;
            m_ack_o[src]   = s_ack_i & resp_ok;
            m_err_o[src]   = s_err_i & resp_ok;
        end
    end

    assign cnt_inc = s_stb_o & ~s_stall_i;
    assign cnt_dec = (s_ack_i | s_err_i) & resp_ok;

    // Track requests accepted by the slave but not yet answered.
    // An abandoned cycle clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= '0;
        end else if (released) begin
            out_cnt <= '0;
        end else if (cnt_inc && !cnt_dec && !(&out_cnt)) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

`ifndef SYNTHESIS
    sat_chk: assert property (@(posedge clk) disable iff (!rst)
                              !(cnt_inc && !cnt_dec && (&out_cnt)));
`endif

endmodule

// File: doc/mr_wb_arb.md
Name: mr_wb_arb

Overview:
- Two-master to one-slave pipelined Wishbone (B4) arbiter that shares the single memory bus between instruction fetch (m0) and load/store (m1).
- Grant is registered and held for a master's entire bus cycle, i.e. while its cyc is high.
- The slave request signals are muxed from the granted master. Responses are steered back only to that master.

Parameters:
- AW, `XLEN-`XLEN_GRAN: word-address width.
- DW, `XLEN: data width.
- OUTW, 4: width of the outstanding-request counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- m_cyc_i  in  2  per-master cyc (bit0=fetch, bit1=ldst)
- m_stb_i  in  2  per-master stb
- m_we_i  in  2  per-master we
- m_addr_i  in  2*AW  per-master word address, m0 in low slice
- m_sel_i  in  2*DW/8  per-master byte selects
- m_dat_i  in  2*DW  per-master write data
- m_ack_o  out  2  per-master ack
- m_err_o  out  2  per-master err
- m_stall_o  out  2  per-master stall
- m_dat_o  out  DW  read data, broadcast to both masters
- s_cyc_o  out  1  slave cyc
- s_stb_o  out  1  slave stb
- s_we_o  out  1  slave we
- s_addr_o  out  AW  slave word address
- s_sel_o  out  DW/8  slave byte selects
- s_dat_o  out  DW  slave write data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- s_stall_i  in  1  slave stall
- s_dat_i  in  DW  slave read data

Behaviour:
- States: IDLE, GNT0, GNT1. Reset (rst low, asynchronous) forces IDLE, clears outstanding count to 0 and clears the last-grant bit to 0.
- Reset-time output values: s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0, m_stall_o=2'b11.
- Outputs in IDLE: s_cyc_o=0, s_stb_o=0, m_stall_o=2'b11, m_ack_o=0, m_err_o=0. s_we/addr/sel/dat follow m1 (don't-care).
- IDLE transitions: IDLE->GNTx on the clock edge where m_cyc_i[x]=1.
  - Arbitration latency is 1 cycle: a master raising cyc+stb sees stall=1 for at least its first cycle.
  - Tie (both cyc high): m1 (ldst) wins.
- Outputs in GNTx:
  - s_cyc_o = m_cyc_i[x]; s_stb_o = m_stb_i[x]; s_we/addr/sel/dat come from master x.
  - m_stall_o[x] = s_stall_i; m_ack_o[x] = s_ack_i; m_err_o[x] = s_err_i.
  - Non-granted master: stall=1, ack=0, err=0.
- Release from GNTx: when m_cyc_i[x]=0 at a clock edge.
  - Next state is GNTy if m_cyc_i[y]=1 (direct hand-off, no IDLE bubble), else IDLE.
  - Hand-off and fresh arbitration both register new grant; no combinational grant change mid-cycle.
- Outstanding counter:
  - Increments on s_stb_o & !s_stall_i.
  - Decrements on s_ack_i | s_err_i.
  - Both in one cycle: unchanged.
  - Saturates at 2^OUTW-1 (flagged via assertion).
  - Cleared to 0 whenever the granted master drops cyc (abandoned cycle).
- Responses arriving while outstanding=0 or in IDLE are discarded: no m_ack_o/m_err_o pulses.
- Error: s_err_i is passed to the granted master only. The grant is held until that master drops cyc. The arbiter itself takes no recovery action.
- Grant never changes while the granted master holds cyc, regardless of the other master's request.

Optional Feature:
- MR_WB_ARB_RR_EN defined: round-robin tie-break. On a tie (IDLE or hand-off with both requesting), the master not granted most recently wins. The last-grant bit updates on each grant.
- Not defined: fixed priority, m1 always wins ties. The last-grant bit is absent.

Decomposition:
- Package mr_wb_pkg holds:
  - enum e_arb_state {ARB_IDLE, ARB_GNT0, ARB_GNT1}
  - localparam ARB_NMASTERS=2
  - master index constants M_FETCH=0, M_LDST=1
- Sub-module mr_wb_arb_pick: combinational 2-way picker. Inputs: req[1:0], last, rr_en. Output: winner index. It is reused by the future 3-master (debug port) variant.

Test Plan:
- Single ldst read, no stall: m1 cyc/stb asserted at cycle 0 -> stall=1 at cycle 0, s_stb_o=1 with m1 addr at cycle 1, s_ack_i at cycle 2 -> m_ack_o=2'b10, m_dat_o=s_dat_i=32'hDEADBEEF.
- Simultaneous requests, fixed priority: both cyc high from IDLE -> GNT1 first. m0 stall=1 throughout. m1 drops cyc -> GNT0 on the next edge with no IDLE cycle.
- Round-robin (MR_WB_ARB_RR_EN): four back-to-back contended cycles -> grant order 1,0,1,0.
- Pipelined burst: m0 issues 3 stb with s_stall_i high on the 2nd -> outstanding peaks at 2 then returns to 0. Exactly 3 m_ack_o[0] pulses; m_ack_o[1] stays 0.
- Error and abandon: slave err on an m1 load -> m_err_o[1]=1 for one cycle. m1 drops cyc -> counter=0. A late s_ack_i in IDLE produces no m_ack_o.
- Async reset mid-cycle: rst low while GNT0 with outstanding=2 -> immediately s_cyc_o=0 and m_stall_o=2'b11. After release, the next request is arbitrated from IDLE.
